// File: rtl/instr_sequencer_if.sv
// Memory handshake bundle for instr_sequencer.
//   mem_req   : request, driven by the sequencer (master)
//   mem_addr  : word address, driven by the sequencer
//   mem_ack   : completion, driven by memory (slave); only meaningful while mem_req=1
//   mem_rdata : read data, driven by memory; sampled on the cycle mem_req & mem_ack
interface instr_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic                mem_req;
  logic [PC_WIDTH-1:0] mem_addr;
  logic                mem_ack;
  logic [15:0]         mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXEC/WB sequencer.
// Owns pc and ir, fetches over a req/ack memory handshake, gates the control
// unit with exec_en / wb_en, and resolves JMP (E), JZ (D), LOAD (8), HALT (F).
//
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   run          : level; permits starting/continuing execution
//   flag         : datapath zero flag, sampled in WB for JZ
//   mem          : instr_sequencer_if.master (mem_req/mem_addr/mem_ack/mem_rdata)
//   ir, opcode   : instruction register and ir[15:12]
//   phase        : current state (IDLE=0 FETCH=1 DECODE=2 EXEC=3 WB=4 HALT=5)
//   exec_en      : high in EXEC
//   wb_en        : high for the single WB cycle
//   halted       : high in HALT
//   fault        : sticky memory-timeout indication
//   instr_count  : retired-instruction counter (counts in WB)
//
// Optional feature: define SEQ_TIMEOUT_EN to enable a memory wait timeout of
// MEM_TIMEOUT cycles in FETCH and LOAD EXEC; otherwise waits forever, fault=0.
module instr_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                flag,
  instr_sequencer_if.master   mem,
  output logic [15:0]         ir,
  output logic [3:0]          opcode,
  output logic [2:0]          phase,
  output logic                exec_en,
  output logic                wb_en,
  output logic                halted,
  output logic                fault,
  output logic [15:0]         instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_LOAD = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  if (PC_WIDTH < 1 || PC_WIDTH > 12) begin : g_pcw_chk
    $error("PC_WIDTH must be 1..12 so the address field fits below the opcode");
  end
  if (MEM_TIMEOUT < 1) begin : g_to_chk
    $error("MEM_TIMEOUT must be at least 1");
  end

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc;
  logic                is_load;
  logic                timeout;

  assign is_load = (ir[15:12] == OP_LOAD);

  // ---------------------------------------------------------------------------
  // Optional memory wait timeout
  // ---------------------------------------------------------------------------
`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          waiting;

  assign waiting = (state == S_FETCH) || (state == S_EXEC && is_load);
  // The cycle holding count MEM_TIMEOUT-1 is the MEM_TIMEOUT-th wait cycle;
  // an ack in that cycle still wins over the timeout.
  assign timeout = waiting && !mem.mem_ack && (wait_cnt == TW'(MEM_TIMEOUT - 1));

  // Every state that precedes FETCH or LOAD EXEC is a non-waiting state, so
  // clearing while not waiting gives a fresh count on each entry.
  always_ff @(posedge clk) begin
    if (reset || !waiting || mem.mem_ack) wait_cnt <= '0;
    else                                  wait_cnt <= wait_cnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)        fault <= 1'b0;
    else if (timeout) fault <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:   state_nxt = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        if (mem.mem_ack)  state_nxt = S_DECODE;
        else if (timeout) state_nxt = S_HALT;
        else              state_nxt = S_FETCH;
      end
      S_DECODE: state_nxt = (ir[15:12] == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (!is_load)     state_nxt = S_WB;
        else if (mem.mem_ack) state_nxt = S_WB;
        else if (timeout) state_nxt = S_HALT;
        else              state_nxt = S_EXEC;
      end
      S_WB:     state_nxt = run ? S_FETCH : S_IDLE;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;  // encodings 6/7 recover to IDLE
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_addr = pc;
    exec_en      = 1'b0;
    wb_en        = 1'b0;
    halted       = 1'b0;
    case (state)
      S_FETCH: mem.mem_req = 1'b1;
      S_EXEC: begin
        exec_en = 1'b1;
        if (is_load) begin
          mem.mem_req  = 1'b1;
          mem.mem_addr = ir[PC_WIDTH-1:0];
        end
      end
      S_WB:    wb_en  = 1'b1;
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign phase  = state;
  assign opcode = ir[15:12];

  // ---------------------------------------------------------------------------
  // Architectural registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ir <= '0;
    end else if (state == S_FETCH && mem.mem_ack) begin
      ir <= mem.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      instr_count <= '0;
    end else if (state == S_WB) begin
      instr_count <= instr_count + 16'd1;
      if (ir[15:12] == OP_JMP || (ir[15:12] == OP_JZ && flag))
        pc <= ir[PC_WIDTH-1:0];
      else
        pc <= pc + PC_WIDTH'(1);
    end
  end

endmodule
